// File: rtl/rtc_read_sequencer.sv
// rtc_read_sequencer
//   Bus-level read engine for a parallel multiplexed address/data RTC.
//   While Ini_Read is high it sweeps a fixed table of RTC register
//   addresses, doing one address-write / data-read access per entry, and
//   writes each returned byte into the time/date/timer register bank.
//   L_Read pulses once after every complete sweep.
//
// Ports
//   Clock     in   system clock
//   Reset     in   synchronous, active-high reset
//   Ini_Read  in   level enable; high = keep sweeping
//   AD_in     in   [7:0] RTC bus read data
//   CS_n      out  RTC chip select (active low)
//   RD_n      out  RTC read strobe (active low)
//   WR_n      out  RTC write strobe (active low)
//   AD_sel    out  RTC A/D_n pin; 0 = address phase, 1 = data
//   AD_out    out  [7:0] address byte driven onto the bus
//   AD_oe     out  tristate enable for AD_out; 1 = FPGA drives the bus
//   Reg_Addr  out  [3:0] register-bank index (current table index)
//   Reg_Data  out  [7:0] captured byte for the bank
//   Reg_WE    out  one-cycle bank write strobe
//   L_Read    out  one-cycle pulse when a full sweep completes
//
// State   | meaning
// IDLE    | bus released, waiting for Ini_Read
// ADDR    | address phase: CS_n/WR_n low, FPGA drives table address
// GAP1    | strobes released, address still driven
// DATA    | read phase: CS_n/RD_n low, bus released by FPGA, byte captured
// GAP2    | bus fully released
// STORE   | one-cycle bank write of the captured byte
// DONE    | one-cycle sweep-complete pulse
module rtc_read_sequencer #(
  parameter int T_PHASE = 10,
  parameter int N_REGS  = 9
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Ini_Read,
  input  logic [7:0] AD_in,
  output logic       CS_n,
  output logic       RD_n,
  output logic       WR_n,
  output logic       AD_sel,
  output logic [7:0] AD_out,
  output logic       AD_oe,
  output logic [3:0] Reg_Addr,
  output logic [7:0] Reg_Data,
  output logic       Reg_WE,
  output logic       L_Read
);

  localparam logic [7:0] PH_LAST  = 8'(T_PHASE - 1);
  localparam logic [3:0] IDX_LAST = 4'(N_REGS - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, GAP1, DATA, GAP2, STORE, DONE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] phase_cnt_q, phase_cnt_d;
  logic [3:0] index_q, index_d;
  logic [7:0] data_q, data_d;
  logic       phase_done;

  function automatic logic [7:0] rtc_addr(input logic [3:0] idx);
    case (idx)
      4'd0:    rtc_addr = 8'h21;
      4'd1:    rtc_addr = 8'h22;
      4'd2:    rtc_addr = 8'h23;
      4'd3:    rtc_addr = 8'h24;
      4'd4:    rtc_addr = 8'h25;
      4'd5:    rtc_addr = 8'h26;
      4'd6:    rtc_addr = 8'h41;
      4'd7:    rtc_addr = 8'h42;
      4'd8:    rtc_addr = 8'h43;
      default: rtc_addr = 8'h00;
    endcase
  endfunction

  assign phase_done = (phase_cnt_q == PH_LAST);

  // State register and datapath registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      phase_cnt_q <= 8'd0;
      index_q     <= 4'd0;
      data_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      index_q     <= index_d;
      data_q      <= data_d;
    end
  end

  // Next-state logic. Ini_Read is only looked at in IDLE and STORE so an
  // access in flight always runs to its bank write.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    data_d  = data_q;
    case (state_q)
      IDLE:  if (Ini_Read) begin
               state_d = ADDR;
               index_d = 4'd0;
             end
      ADDR:  if (phase_done) state_d = GAP1;
      GAP1:  if (phase_done) state_d = DATA;
      DATA:  if (phase_done) begin
               state_d = GAP2;
               data_d  = AD_in;
             end
      GAP2:  if (phase_done) state_d = STORE;
      STORE: if (!Ini_Read) begin
               state_d = IDLE;
               index_d = 4'd0;
             end else if (index_q == IDX_LAST) begin
               state_d = DONE;
             end else begin
               state_d = ADDR;
               index_d = index_q + 4'd1;
             end
      DONE:  begin
               state_d = IDLE;
               index_d = 4'd0;
             end
      default: state_d = IDLE;
    endcase
    phase_cnt_d = (state_d != state_q) ? 8'd0 : phase_cnt_q + 8'd1;
  end

  // Moore output decode
  always_comb begin
    CS_n   = 1'b1;
    RD_n   = 1'b1;
    WR_n   = 1'b1;
    AD_sel = 1'b1;
    AD_oe  = 1'b0;
    AD_out = 8'h00;
    Reg_WE = 1'b0;
    L_Read = 1'b0;
    case (state_q)
      ADDR: begin
        CS_n   = 1'b0;
        WR_n   = 1'b0;
        AD_sel = 1'b0;
        AD_oe  = 1'b1;
        AD_out = rtc_addr(index_q);
      end
      GAP1: begin
        AD_sel = 1'b0;
        AD_oe  = 1'b1;
        AD_out = rtc_addr(index_q);
      end
      DATA: begin
        CS_n = 1'b0;
        RD_n = 1'b0;
      end
      STORE:   Reg_WE = 1'b1;
      DONE:    L_Read = 1'b1;
      default: ;
    endcase
  end

  assign Reg_Addr = index_q;
  assign Reg_Data = data_q;

endmodule

// File: tb/tb_rtc_read_sequencer.sv
module tb_rtc_read_sequencer;

  logic       Clock = 1'b0;
  logic       Reset, Ini_Read;
  logic [7:0] AD_in;
  logic       CS_n, RD_n, WR_n, AD_sel, AD_oe, Reg_WE, L_Read;
  logic [7:0] AD_out, Reg_Data;
  logic [3:0] Reg_Addr;

  logic       Reset2, Ini_Read2;
  logic       CS_n2, RD_n2, WR_n2, AD_sel2, AD_oe2, Reg_WE2, L_Read2;
  logic [7:0] AD_out2, Reg_Data2;
  logic [3:0] Reg_Addr2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 Clock = ~Clock;

  rtc_read_sequencer dut (
    .Clock(Clock), .Reset(Reset), .Ini_Read(Ini_Read), .AD_in(AD_in),
    .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n), .AD_sel(AD_sel),
    .AD_out(AD_out), .AD_oe(AD_oe), .Reg_Addr(Reg_Addr),
    .Reg_Data(Reg_Data), .Reg_WE(Reg_WE), .L_Read(L_Read)
  );

  rtc_read_sequencer #(.T_PHASE(2), .N_REGS(9)) dut2 (
    .Clock(Clock), .Reset(Reset2), .Ini_Read(Ini_Read2), .AD_in(8'h00),
    .CS_n(CS_n2), .RD_n(RD_n2), .WR_n(WR_n2), .AD_sel(AD_sel2),
    .AD_out(AD_out2), .AD_oe(AD_oe2), .Reg_Addr(Reg_Addr2),
    .Reg_Data(Reg_Data2), .Reg_WE(Reg_WE2), .L_Read(L_Read2)
  );

  // RTC model: latches the address written in the address phase and
  // answers either 0x45 for 0x21 (mode 0) or address ^ 0xFF (mode 1).
  logic [7:0] addr_lat = 8'h00;
  logic       mode = 1'b0;
  always @(posedge Clock)
    if (!CS_n && !WR_n && !AD_sel) addr_lat <= AD_out;
  assign AD_in = mode ? (addr_lat ^ 8'hFF) : ((addr_lat == 8'h21) ? 8'h45 : 8'h00);

  logic [12:0] bus;
  assign bus = {CS_n, RD_n, WR_n, AD_sel, AD_oe, AD_out};
  localparam logic [12:0] BUS_REL = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};

  logic [7:0] addr_tab [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
  logic [7:0] data_tab [9] = '{8'hDE, 8'hDD, 8'hDC, 8'hDB, 8'hDA, 8'hD9, 8'hBE, 8'hBD, 8'hBC};

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Ini_Read = 1'b0;
    repeat (3) step();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    int bad = 0;
    do_reset();
    n_checks++;
    if (bus !== BUS_REL) $display("FAIL reset_bus got %h want %h", bus, BUS_REL);
    else n_pass++;
    n_checks++;
    if ({Reg_Addr, Reg_Data, Reg_WE, L_Read} !== 14'h0)
      $display("FAIL reset_bank got %h want 0", {Reg_Addr, Reg_Data, Reg_WE, L_Read});
    else n_pass++;
    for (int k = 0; k < 30; k++) begin
      step();
      if (bus !== BUS_REL || Reg_WE !== 1'b0 || L_Read !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL reset_idle_hold got %0d bad cycles want 0", bad);
    else n_pass++;
  endtask

  task automatic test_single_access();
    logic [12:0] exp, msk;
    mode = 1'b0;
    do_reset();
    Ini_Read = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      step();
      msk = 13'h1FFF;
      if (k < 10)      exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h21};
      else if (k < 20) begin
        exp = {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h21};
        msk = 13'h1DFF;
      end else if (k < 30) begin
        exp = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        msk = 13'h1F00;
      end else exp = BUS_REL;
      n_checks++;
      if ((bus & msk) !== (exp & msk))
        $display("FAIL single_bus k=%0d got %h want %h", k, bus & msk, exp & msk);
      else n_pass++;
      n_checks++;
      if (Reg_WE !== (k == 40))
        $display("FAIL single_we k=%0d got %b want %b", k, Reg_WE, (k == 40));
      else n_pass++;
    end
    n_checks++;
    if ({Reg_Addr, Reg_Data} !== {4'd0, 8'h45})
      $display("FAIL single_store got %h/%h want 0/45", Reg_Addr, Reg_Data);
    else n_pass++;
    Ini_Read = 1'b0;
  endtask

  task automatic test_full_sweep();
    int idx;
    mode = 1'b1;
    do_reset();
    Ini_Read = 1'b1;
    for (int k = 0; k <= 371; k++) begin
      step();
      idx = k / 41;
      if (k < 369 && (k % 41) == 0) begin
        n_checks++;
        if (CS_n !== 1'b0 || WR_n !== 1'b0 || AD_out !== addr_tab[idx])
          $display("FAIL sweep_addr k=%0d got %b%b/%h want 00/%h", k, CS_n, WR_n, AD_out, addr_tab[idx]);
        else n_pass++;
      end
      n_checks++;
      if (Reg_WE !== (k < 369 && (k % 41) == 40))
        $display("FAIL sweep_we k=%0d got %b", k, Reg_WE);
      else n_pass++;
      if (k < 369 && (k % 41) == 40) begin
        n_checks++;
        if ({Reg_Addr, Reg_Data} !== {4'(idx), data_tab[idx]})
          $display("FAIL sweep_store k=%0d got %h/%h want %h/%h", k, Reg_Addr, Reg_Data, idx, data_tab[idx]);
        else n_pass++;
      end
      n_checks++;
      if (L_Read !== (k == 369)) $display("FAIL sweep_lread k=%0d got %b", k, L_Read);
      else n_pass++;
    end
    n_checks++;
    if (CS_n !== 1'b0 || AD_out !== 8'h21)
      $display("FAIL sweep_restart got %b/%h want 0/21", CS_n, AD_out);
    else n_pass++;
    Ini_Read = 1'b0;
  endtask

  task automatic test_drop_enable();
    int bad = 0;
    mode = 1'b1;
    do_reset();
    Ini_Read = 1'b1;
    for (int k = 0; k <= 263; k++) begin
      step();
      if (k == 145) Ini_Read = 1'b0;
      if (k == 163) begin
        n_checks++;
        if ({Reg_WE, Reg_Addr, Reg_Data} !== {1'b1, 4'd3, 8'hDB})
          $display("FAIL drop_store got %b/%h/%h want 1/3/db", Reg_WE, Reg_Addr, Reg_Data);
        else n_pass++;
      end
      if (L_Read !== 1'b0) bad++;
      if (k > 163 && (CS_n !== 1'b1 || Reg_WE !== 1'b0)) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL drop_quiet got %0d bad cycles want 0", bad);
    else n_pass++;
    n_checks++;
    if (Reg_Addr !== 4'd0) $display("FAIL drop_index got %h want 0", Reg_Addr);
    else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    int bad = 0;
    mode = 1'b1;
    do_reset();
    Ini_Read = 1'b1;
    for (int k = 0; k <= 260; k++) begin
      step();
      if (k == 215) begin
        n_checks++;
        if (AD_oe !== 1'b1 || AD_out !== 8'h26 || CS_n !== 1'b1)
          $display("FAIL rst_gap1 got %b/%h/%b want 1/26/1", AD_oe, AD_out, CS_n);
        else n_pass++;
      end
      if (k == 218) Reset = 1'b1;
      if (k == 219) begin
        n_checks++;
        if (bus !== BUS_REL) $display("FAIL rst_release got %h want %h", bus, BUS_REL);
        else n_pass++;
        Reset = 1'b0;
      end
      if (k >= 219 && k < 260 && Reg_WE !== 1'b0) bad++;
      if (k == 220) begin
        n_checks++;
        if (CS_n !== 1'b0 || AD_out !== 8'h21)
          $display("FAIL rst_restart got %b/%h want 0/21", CS_n, AD_out);
        else n_pass++;
      end
      if (k == 260) begin
        n_checks++;
        if ({Reg_WE, Reg_Addr, Reg_Data} !== {1'b1, 4'd0, 8'hDE})
          $display("FAIL rst_store got %b/%h/%h want 1/0/de", Reg_WE, Reg_Addr, Reg_Data);
        else n_pass++;
      end
    end
    n_checks++;
    if (bad != 0) $display("FAIL rst_no_we got %0d strobes want 0", bad);
    else n_pass++;
    Ini_Read = 1'b0;
  endtask

  task automatic test_back_to_back();
    int contention = 0, badlen = 0, pulses = 0, run = 0, lreads = 0;
    Reset2 = 1'b1;
    Ini_Read2 = 1'b0;
    repeat (3) step();
    Reset2 = 1'b0;
    Ini_Read2 = 1'b1;
    for (int k = 0; k <= 248; k++) begin
      step();
      if (AD_oe2 === 1'b1 && RD_n2 === 1'b0) contention++;
      if (RD_n2 === 1'b0 && WR_n2 === 1'b0) contention++;
      if (L_Read2 === 1'b1) lreads++;
      if (CS_n2 === 1'b0) run++;
      else if (run > 0) begin
        pulses++;
        if (run != 2) badlen++;
        run = 0;
      end
    end
    Ini_Read2 = 1'b0;
    n_checks++;
    if (contention != 0) $display("FAIL b2b_contention got %0d want 0", contention);
    else n_pass++;
    n_checks++;
    if (badlen != 0) $display("FAIL b2b_cs_width got %0d bad pulses want 0", badlen);
    else n_pass++;
    n_checks++;
    if (pulses != 54) $display("FAIL b2b_cs_count got %0d want 54", pulses);
    else n_pass++;
    n_checks++;
    if (lreads != 3) $display("FAIL b2b_lread got %0d want 3", lreads);
    else n_pass++;
  endtask

  initial begin
    Reset = 1'b1;
    Ini_Read = 1'b0;
    Reset2 = 1'b1;
    Ini_Read2 = 1'b0;
    test_reset();
    test_single_access();
    test_full_sweep();
    test_drop_enable();
    test_reset_mid_access();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
